cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares one registered writeback/CDB broadcast port among NUM_REQ execute-lane result FIFOs.
- Each FIFO presents an EX_PACKET with a valid flag.
- The arbiter grants one requester per cycle in round-robin order and pops it via req_ready.
- It holds the broadcast register under downstream stall and clears it on squash.
- Sits between the per-lane FIFOs and the complete/retire stage.

Parameters:
- NUM_REQ, 4, number of requesting lanes (>=2, power of two not required).
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  lane i has a packet at its FIFO head.
- req_packet  in  NUM_REQ x EX_PACKET  head packet of each lane.
- req_ready  out  NUM_REQ  one-hot pop; lane i's head is consumed at this clock edge.
- cdb_stall  in  1  downstream cannot accept the broadcast this cycle.
- squash  in  1  synchronous flush (branch mispredict).
- cdb_valid  out  1  broadcast register holds a valid packet.
- cdb_packet  out  EX_PACKET  registered broadcast packet.
- cdb_src  out  $clog2(NUM_REQ)  lane index of the current cdb_packet.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - cdb_valid=0, cdb_packet all-zero, cdb_src=0, rr_ptr=0.
  - req_ready=0 while reset is asserted.
- load_en = !squash && (!cdb_valid || !cdb_stall).
- Grant is combinational:
  - If load_en, scan lanes rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first lane with req_valid=1 is granted; only that lane gets req_ready=1, in the same cycle.
  - No valid lanes, or !load_en: req_ready all 0.
- Latency: the granted packet appears on cdb_packet with cdb_valid=1 at the next rising edge (1 cycle). cdb_src = granted index.
- rr_ptr <= (grant_idx+1) mod NUM_REQ on a grant. Otherwise unchanged.
  - Wrap: grant of lane NUM_REQ-1 sets rr_ptr=0.
  - Non-power-of-two NUM_REQ wraps correctly.
- Drain without refill:
  - If load_en is true and no lane is valid, cdb_valid <= 0 next edge.
  - cdb_packet is then don't-care; the implementation keeps the old value.
- Stall: cdb_valid=1 && cdb_stall=1 → cdb_packet, cdb_src and cdb_valid held; no req_ready.
- Stall while cdb_valid=0 has no effect: the register is empty and may load.
- Squash (synchronous):
  - cdb_valid <= 0 and req_ready all 0 that cycle.
  - rr_ptr preserved.
  - Squash overrides stall.
- The packet is forwarded bit-exact; packet.valid is not inspected. req_valid alone qualifies a request.
- Simultaneous squash and reset: reset wins.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- Defined:
  - Adds outputs grant_cnt[NUM_REQ] x CNT_W (per-lane grants) and stall_cnt CNT_W (cycles with cdb_valid && cdb_stall).
  - All counters saturate at all-ones and reset to 0.
  - Squash does not clear them.
- Undefined: these ports and all counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- The EX_PACKET typedef and XLEN stay in the shared system-definitions package.
- Add ARB_IDX_W = $clog2(NUM_REQ) as a localparam, not a package constant.
- One natural sub-module: rr_picker.
  - Combinational rotate-priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, grant_idx, any_grant.

Test Plan:
- Reset: hold reset=0 with req_valid=1111 → cdb_valid=0, req_ready=0000. Assert reset mid-broadcast (between edges) → cdb_valid drops immediately.
- Single lane: req_valid=0010, lane1 alu_result=100 → req_ready=0010 same cycle; next edge cdb_valid=1, alu_result 100, cdb_src=1. Then with req_valid=0000 → cdb_valid=0.
- Full fairness: all four lanes valid continuously with alu 100/200/300/400 → broadcasts 100,200,300,400,100, one per cycle; rr_ptr wraps 3→0.
- Stall: stall=1 for 3 cycles while cdb shows 200 → 200 held, req_ready=0000 each stalled cycle. Deassert → 300 next edge.
- Squash: squash=1 while cdb shows 300 and all lanes valid → next edge cdb_valid=0, no pop that cycle. Following grant goes to lane 3 (rr_ptr preserved).
- Perf (CDB_ARB_PERF_EN): after the fairness run of 8 grants plus a 3-cycle stall → grant_cnt all 2, stall_cnt=3.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cdb_arbiter_pkg                                                    |
// | Shared system definitions: datapath width and execute-lane result packet.  |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
package cdb_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] dest_preg;
    logic [XLEN-1:0]   alu_result;
  } ex_packet_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_picker                                                          |
// | Combinational rotate-priority encoder: first set request at/after rr_ptr.  |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  localparam logic [IDX_W:0] C_NUM_REQ = (IDX_W+1)'(NUM_REQ);

  always_comb begin : p_pick
    logic [IDX_W:0] w_lane;
    w_lane    = '0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // rr_ptr < NUM_REQ always, so one conditional subtract wraps the sum.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_lane = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (w_lane >= C_NUM_REQ) begin
        w_lane = w_lane - C_NUM_REQ;
      end
      if (!any_grant && req[w_lane[IDX_W-1:0]]) begin
        any_grant = 1'b1;
        grant_idx = w_lane[IDX_W-1:0];
      end
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cdb_arbiter                                                        |
// | Round-robin arbiter driving one registered CDB broadcast port from NUM_REQ |
// | lane FIFOs. Define CDB_ARB_PERF_EN to add saturating grant/stall counters. |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
`ifdef CDB_ARB_PERF_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  ex_packet_t [NUM_REQ-1:0]   req_packet,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cdb_stall,
  input  logic                       squash,
  output logic                       cdb_valid,
  output ex_packet_t                 cdb_packet,
  output logic [$clog2(NUM_REQ)-1:0] cdb_src
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0]              stall_cnt
`endif
);

  localparam int ARB_IDX_W = $clog2(NUM_REQ);

  logic                 r_cdb_valid;
  ex_packet_t           r_cdb_packet;
  logic [ARB_IDX_W-1:0] r_cdb_src;
  logic [ARB_IDX_W-1:0] r_rr_ptr;

  logic                 w_load_en;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ARB_IDX_W-1:0] w_grant_idx;
  logic                 w_any_grant;

  // Folding reset in keeps req_ready low while reset is held, even though the
  // cleared register would otherwise look ready to load.
  assign w_load_en = reset && !squash && (!r_cdb_valid || !cdb_stall);

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ARB_IDX_W)
  ) u_rr_picker (
    .req       (req_valid & {NUM_REQ{w_load_en}}),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_grant (w_any_grant)
  );

  assign req_ready = w_grant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_packet <= '0;
      r_cdb_src    <= '0;
      r_rr_ptr     <= '0;
    end else if (squash) begin
      r_cdb_valid <= 1'b0;
    end else if (w_load_en) begin
      r_cdb_valid <= w_any_grant;
      if (w_any_grant) begin
        r_cdb_packet <= req_packet[w_grant_idx];
        r_cdb_src    <= w_grant_idx;
        r_rr_ptr     <= (w_grant_idx == ARB_IDX_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_packet = r_cdb_packet;
  assign cdb_src    = r_cdb_src;

`ifdef CDB_ARB_PERF_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] r_grant_cnt;
  logic [CNT_W-1:0]              r_stall_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_grant_cnt[g] <= '0;
      end else if (w_grant[g] && (r_grant_cnt[g] != {CNT_W{1'b1}})) begin
        r_grant_cnt[g] <= r_grant_cnt[g] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (r_cdb_valid && cdb_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
